// File: rtl/ex_muldiv_if.sv
// Handshake bundle between the EX stage and the iterative multiply/divide unit.
// The pipeline side is the master and the arithmetic unit is the slave.
interface ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic                 start_i;
  logic [1:0]           op_i;
  logic [WIDTH-1:0]     opa_i;
  logic [WIDTH-1:0]     opb_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 stallreq;

  modport master (
    output start_i, op_i, opa_i, opb_i, annul_i,
    input  result_o, ready_o, stallreq
  );

  modport slave (
    input  start_i, op_i, opa_i, opb_i, annul_i,
    output result_o, ready_o, stallreq
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply/divide unit for the EX stage: MULT/MULTU/DIV/DIVU
// producing {HI,LO} after WIDTH iterations, with stall request and annul.
module ex_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic          clk,
  input logic          rst,
  ex_muldiv_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opd;
  logic                 is_div;
  logic                 sa;
  logic                 sb;
  logic                 ready_q;
  logic [2*WIDTH-1:0]   result_q;

  logic                 is_signed;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 accept;
  logic                 div_zero;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   step;
  logic [WIDTH-1:0]     quot;
  logic [WIDTH-1:0]     rem;
  logic [2*WIDTH-1:0]   fix;

  always_comb begin
    is_signed = ~bus.op_i[0];
    a_neg     = is_signed & bus.opa_i[WIDTH-1];
    b_neg     = is_signed & bus.opb_i[WIDTH-1];
    a_mag     = a_neg ? -bus.opa_i : bus.opa_i;
    b_mag     = b_neg ? -bus.opb_i : bus.opb_i;
    accept    = bus.start_i & ~bus.annul_i;
    div_zero  = bus.op_i[1] & (bus.opb_i == '0);
  end

  // Multiply keeps the multiplier in acc's low half and shifts the product in from the top;
  // divide shifts {rem,quot} left and inserts quotient bits at the bottom.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opd};
    div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opd};
    if (is_div) begin
      if (div_diff[WIDTH])
        step = {acc[2*WIDTH-2:0], 1'b0};
      else
        step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      if (acc[0])
        step = {mul_sum, acc[WIDTH-1:1]};
      else
        step = {1'b0, acc[2*WIDTH-1:1]};
    end
    quot = step[WIDTH-1:0];
    rem  = step[2*WIDTH-1:WIDTH];
    fix  = step;
    if (is_div)
      fix = {(sa ? -rem : rem), ((sa ^ sb) ? -quot : quot)};
    else if (sa ^ sb)
      fix = -step;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opd      <= '0;
      is_div   <= 1'b0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            is_div <= bus.op_i[1];
            sa     <= a_neg;
            sb     <= b_neg;
            cnt    <= '0;
            if (div_zero) begin
              result_q <= {bus.opa_i, {WIDTH{1'b1}}};
              ready_q  <= 1'b1;
              state    <= DONE;
            end else begin
              acc   <= bus.op_i[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
              opd   <= bus.op_i[1] ? b_mag : a_mag;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.annul_i) begin
            state <= IDLE;
          end else begin
            acc <= step;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH-1)) begin
              result_q <= fix;
              ready_q  <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q & ~bus.annul_i & (state == DONE);
  assign bus.stallreq = ~rst & (((state == IDLE) & accept) | (state == CALC));

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv at WIDTH=32: arithmetic results, latency, stall,
// annul, back-to-back starts and mid-operation reset.
module tb_ex_muldiv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  ex_muldiv_if #(.WIDTH(32)) bus ();

  ex_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  // Start an operation in cycle 0, then watch 40 more cycles.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int rdy_cyc, output int rdy_cnt, output int stall_cnt,
                        output logic [63:0] res);
    rdy_cyc = -1; rdy_cnt = 0; stall_cnt = 0; res = '0;
    @(posedge clk); #1;
    bus.op_i = op; bus.opa_i = a; bus.opb_i = b; bus.start_i = 1'b1; #1;
    if (bus.stallreq) stall_cnt++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      bus.start_i = 1'b0; #1;
      if (bus.stallreq) stall_cnt++;
      if (bus.ready_o) begin
        rdy_cnt++;
        if (rdy_cyc < 0) begin rdy_cyc = k; res = bus.result_o; end
      end
    end
  endtask

  task automatic check_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res, input int exp_cyc);
    int rc, rn, sc;
    logic [63:0] r;
    run_op(op, a, b, rc, rn, sc, r);
    tests++;
    if (r !== exp_res) begin
      fails++; $display("FAIL %s_result: got %h expected %h", name, r, exp_res);
    end
    tests++;
    if (rc !== exp_cyc) begin
      fails++; $display("FAIL %s_ready_cycle: got %0d expected %0d", name, rc, exp_cyc);
    end
    tests++;
    if (rn !== 1) begin
      fails++; $display("FAIL %s_ready_pulses: got %0d expected 1", name, rn);
    end
    tests++;
    if (sc !== exp_cyc) begin
      fails++; $display("FAIL %s_stall_cycles: got %0d expected %0d", name, sc, exp_cyc);
    end
  endtask

  task automatic test_reset();
    bus.start_i = 1'b1; bus.annul_i = 1'b0; bus.op_i = OP_MULT;
    bus.opa_i = 32'd3; bus.opb_i = 32'd4;
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (bus.stallreq !== 1'b0) begin
      fails++; $display("FAIL reset_stall: got %b expected 0", bus.stallreq);
    end
    tests++;
    if (bus.ready_o !== 1'b0) begin
      fails++; $display("FAIL reset_ready: got %b expected 0", bus.ready_o);
    end
    tests++;
    if (bus.result_o !== 64'h0) begin
      fails++; $display("FAIL reset_result: got %h expected 0", bus.result_o);
    end
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_multiply();
    check_op("mult_neg", OP_MULT, 32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFF_FFFFFFFA, 33);
    check_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 33);
    check_op("mult_pos", OP_MULT, 32'h00001234, 32'h00005678, 64'h00000000_06260060, 33);
  endtask

  task automatic test_divide();
    check_op("div_neg7", OP_DIV, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33);
    check_op("divu_big", OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 33);
    check_op("div_wrap", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
    check_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
  endtask

  task automatic test_div_by_zero();
    check_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1);
    check_op("div_zero_neg", OP_DIV, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, 1);
  endtask

  task automatic test_annul();
    int rn;
    int sn;
    check_op("annul_pre", OP_MULTU, 32'd3, 32'd4, 64'd12, 33);
    // Annul mid-calculation in cycle 10.
    rn = 0;
    @(posedge clk); #1;
    bus.op_i = OP_MULT; bus.opa_i = 32'h1234; bus.opb_i = 32'h5678; bus.start_i = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      if (k == 10) bus.annul_i = 1'b1;
      if (k == 11) bus.annul_i = 1'b0;
      #1;
      if (bus.ready_o) rn++;
      if (k == 10) begin
        tests++;
        if (bus.stallreq !== 1'b1) begin
          fails++; $display("FAIL annul_calc_stall: got %b expected 1", bus.stallreq);
        end
      end
      if (k == 11) begin
        tests++;
        if (bus.stallreq !== 1'b0) begin
          fails++; $display("FAIL annul_idle_stall: got %b expected 0", bus.stallreq);
        end
      end
    end
    tests++;
    if (rn !== 0) begin
      fails++; $display("FAIL annul_ready: got %0d pulses expected 0", rn);
    end
    tests++;
    if (bus.result_o !== 64'd12) begin
      fails++; $display("FAIL annul_result: got %h expected %h", bus.result_o, 64'd12);
    end
    // start and annul together: annul wins.
    rn = 0; sn = 0;
    @(posedge clk); #1;
    bus.op_i = OP_DIVU; bus.opa_i = 32'd9; bus.opb_i = 32'd0;
    bus.start_i = 1'b1; bus.annul_i = 1'b1; #1;
    if (bus.stallreq) sn++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      bus.start_i = 1'b0; bus.annul_i = 1'b0; #1;
      if (bus.ready_o) rn++;
      if (bus.stallreq) sn++;
    end
    tests++;
    if (sn !== 0) begin
      fails++; $display("FAIL start_annul_stall: got %0d stall cycles expected 0", sn);
    end
    tests++;
    if (rn !== 0 || bus.result_o !== 64'd12) begin
      fails++; $display("FAIL start_annul_result: got %0d pulses result %h expected 0 pulses result %h",
                        rn, bus.result_o, 64'd12);
    end
    // Annul during the DONE cycle suppresses ready.
    @(posedge clk); #1;
    bus.op_i = OP_DIVU; bus.opa_i = 32'd5; bus.opb_i = 32'd0; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.annul_i = 1'b1; #1;
    tests++;
    if (bus.ready_o !== 1'b0) begin
      fails++; $display("FAIL annul_done_ready: got %b expected 0", bus.ready_o);
    end
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    int rc;
    rc = -1;
    @(posedge clk); #1;
    bus.op_i = OP_MULTU; bus.opa_i = 32'd6; bus.opb_i = 32'd7; bus.start_i = 1'b1;
    for (int k = 1; k <= 40 && rc < 0; k++) begin
      @(posedge clk); #1;
      bus.start_i = 1'b0; #1;
      if (bus.ready_o) rc = k;
    end
    tests++;
    if (rc !== 33 || bus.result_o !== 64'd42) begin
      fails++; $display("FAIL b2b_first: got cycle %0d result %h expected cycle 33 result %h",
                        rc, bus.result_o, 64'd42);
    end
    // In DONE: a new start must not stall or be taken.
    bus.op_i = OP_DIVU; bus.opa_i = 32'd5; bus.opb_i = 32'd0; bus.start_i = 1'b1; #1;
    tests++;
    if (bus.stallreq !== 1'b0) begin
      fails++; $display("FAIL b2b_done_stall: got %b expected 0", bus.stallreq);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.stallreq !== 1'b1 || bus.ready_o !== 1'b0) begin
      fails++; $display("FAIL b2b_idle_accept: got stall %b ready %b expected stall 1 ready 0",
                        bus.stallreq, bus.ready_o);
    end
    @(posedge clk); #1;
    bus.start_i = 1'b0; #1;
    tests++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h00000005_FFFFFFFF) begin
      fails++; $display("FAIL b2b_second: got ready %b result %h expected ready 1 result %h",
                        bus.ready_o, bus.result_o, 64'h00000005_FFFFFFFF);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.op_i = OP_DIV; bus.opa_i = 32'd100; bus.opb_i = 32'd7; bus.start_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      bus.start_i = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b1; #1;
    tests++;
    if (bus.result_o !== 64'h0 || bus.ready_o !== 1'b0 || bus.stallreq !== 1'b0) begin
      fails++; $display("FAIL reset_mid: got result %h ready %b stall %b expected 0 0 0",
                        bus.result_o, bus.ready_o, bus.stallreq);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    check_op("post_reset_div", OP_DIV, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 33);
  endtask

  initial begin
    bus.start_i = 1'b0; bus.annul_i = 1'b0; bus.op_i = 2'b00;
    bus.opa_i = '0; bus.opb_i = '0;
    test_reset();
    test_multiply();
    test_divide();
    test_div_by_zero();
    test_annul();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
